// File: rtl/vend_coin_sequencer_if.sv
// Coin-side, FSM-side and actuator-side signals of the vending front end.
// The sequencer takes the slave view. The environment (mechanism, FSM,
// motor, hopper) takes the master view.
interface vend_coin_sequencer_if;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       coin_ready;
  logic       one;
  logic       two;
  logic       five;
  logic       fsm_d;
  logic [2:0] fsm_r;
  logic       vend_req;
  logic       vend_ack;
  logic       hop_req;
  logic       hop_ack;
  logic [2:0] change_left;
  logic       reject;
  logic       busy;

  modport master (
    output coin_valid, coin_type, fsm_d, fsm_r, vend_ack, hop_ack,
    input  coin_ready, one, two, five, vend_req, hop_req, change_left, reject, busy
  );

  modport slave (
    input  coin_valid, coin_type, fsm_d, fsm_r, vend_ack, hop_ack,
    output coin_ready, one, two, five, vend_req, hop_req, change_left, reject, busy
  );
endinterface

// File: rtl/vend_coin_sequencer.sv
// Front-end controller for vending_fsm.
// It queues coins and feeds them to the FSM one at a time as single-cycle
// pulses, with a settle gap after each pulse. It turns the FSM's dispense
// and change outputs into handshaked motor and hopper requests. Vend is
// served before change, and change is served before the next coin.
module vend_coin_sequencer #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2
) (
  input logic                  clk,
  input logic                  reset,
  vend_coin_sequencer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(SETTLE) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [SW-1:0] WAIT_ONE   = SW'(1);
  localparam logic [SW-1:0] WAIT_LAST  = SW'(SETTLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_VEND   = 3'd3,
    ST_CHANGE = 3'd4
  } state_t;

  // Change counter update: take off one acked coin, add new change owed,
  // and saturate at 7. The caller only sets dec when the counter is nonzero.
  function automatic logic [2:0] change_update(input logic [2:0] cur,
                                               input logic       dec,
                                               input logic [2:0] add);
    logic [3:0] sum;
    sum = {1'b0, cur} + {1'b0, add} - {3'b000, dec};
    if (sum > 4'd7) begin
      return 3'd7;
    end else begin
      return sum[2:0];
    end
  endfunction

  logic [1:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          full_s;
  logic          empty_s;
  logic          hs_s;
  logic          slug_s;
  logic          push_s;
  logic          pop_s;
  logic [1:0]    head_s;

  state_t        state_r;
  state_t        state_s;
  logic [SW-1:0] wait_cnt_r;
  logic [SW-1:0] wait_cnt_s;
  logic          vend_pend_r;
  logic          vend_pend_s;
  logic          vend_done_s;
  logic [2:0]    change_r;
  logic [2:0]    change_s;
  logic          hop_dec_s;
  logic          one_r;
  logic          one_s;
  logic          two_r;
  logic          two_s;
  logic          five_r;
  logic          five_s;
  logic          vend_req_r;
  logic          vend_req_s;
  logic          hop_req_r;
  logic          hop_req_s;
  logic          reject_r;

  // A full FIFO refuses coins even if a pop is decided in the same cycle,
  // so coin_ready depends only on the registered occupancy.
  assign full_s  = (count_r == FULL_COUNT);
  assign empty_s = (count_r == {CW{1'b0}});
  assign hs_s    = bus.coin_valid & ~full_s;
  assign slug_s  = hs_s & (bus.coin_type == 2'b11);
  assign push_s  = hs_s & (bus.coin_type != 2'b11);
  assign head_s  = mem_r[rd_ptr_r];

  assign bus.coin_ready  = ~full_s;
  assign bus.one         = one_r;
  assign bus.two         = two_r;
  assign bus.five        = five_r;
  assign bus.vend_req    = vend_req_r;
  assign bus.hop_req     = hop_req_r;
  assign bus.change_left = change_r;
  assign bus.reject      = reject_r;
  assign bus.busy        = (state_r != ST_IDLE) | ~empty_s | vend_pend_r | (change_r != 3'd0);

  // Coin FIFO: storage, pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 2'b00;
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= bus.coin_type;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Pending-request monitor, which runs in every state. A new dispense
  // wins over a same-cycle vend ack. An acked coin and new change net out.
  always_comb begin
    vend_done_s = (state_r == ST_VEND) & bus.vend_ack;
    if (bus.fsm_d) begin
      vend_pend_s = 1'b1;
    end else if (vend_done_s) begin
      vend_pend_s = 1'b0;
    end else begin
      vend_pend_s = vend_pend_r;
    end
    hop_dec_s = hop_req_r & bus.hop_ack & (change_r != 3'd0);
    change_s  = change_update(change_r, hop_dec_s, bus.fsm_r);
  end

  // Sequencer next state and next values of the registered outputs.
  always_comb begin
    state_s    = state_r;
    wait_cnt_s = wait_cnt_r;
    pop_s      = 1'b0;
    one_s      = 1'b0;
    two_s      = 1'b0;
    five_s     = 1'b0;
    vend_req_s = vend_req_r;
    hop_req_s  = hop_req_r;
    case (state_r)
      ST_IDLE: begin
        if (vend_pend_r) begin
          state_s    = ST_VEND;
          vend_req_s = 1'b1;
        end else if (change_r != 3'd0) begin
          state_s   = ST_CHANGE;
          hop_req_s = 1'b1;
        end else if (!empty_s) begin
          state_s = ST_ISSUE;
          pop_s   = 1'b1;
          case (head_s)
            2'b00:   one_s  = 1'b1;
            2'b01:   two_s  = 1'b1;
            2'b10:   five_s = 1'b1;
            default: one_s  = 1'b0;
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_s    = ST_WAIT;
        wait_cnt_s = {SW{1'b0}};
      end
      ST_WAIT: begin
        if (wait_cnt_r == WAIT_LAST) begin
          state_s    = ST_IDLE;
          wait_cnt_s = {SW{1'b0}};
        end else begin
          wait_cnt_s = wait_cnt_r + WAIT_ONE;
        end
      end
      ST_VEND: begin
        if (bus.vend_ack) begin
          state_s    = ST_IDLE;
          vend_req_s = 1'b0;
        end else begin
          vend_req_s = 1'b1;
        end
      end
      ST_CHANGE: begin
        if (change_s == 3'd0) begin
          state_s   = ST_IDLE;
          hop_req_s = 1'b0;
        end else begin
          hop_req_s = 1'b1;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        wait_cnt_s = {SW{1'b0}};
        vend_req_s = 1'b0;
        hop_req_s  = 1'b0;
      end
    endcase
  end

  // State, pending flags and output registers. A reset also drops queued
  // coins and owed change, because the FSM shares the same reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      wait_cnt_r  <= {SW{1'b0}};
      vend_pend_r <= 1'b0;
      change_r    <= 3'd0;
      one_r       <= 1'b0;
      two_r       <= 1'b0;
      five_r      <= 1'b0;
      vend_req_r  <= 1'b0;
      hop_req_r   <= 1'b0;
      reject_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      wait_cnt_r  <= wait_cnt_s;
      vend_pend_r <= vend_pend_s;
      change_r    <= change_s;
      one_r       <= one_s;
      two_r       <= two_s;
      five_r      <= five_s;
      vend_req_r  <= vend_req_s;
      hop_req_r   <= hop_req_s;
      reject_r    <= slug_s;
    end
  end

endmodule
